// File: rtl/mem_port_arbiter_if.sv
// Core/RAM bundle for mem_port_arbiter.
//   slave  : the arbiter view (requests and ram_do in; grants, responses and RAM drive out)
//   master : the environment view (core request side plus the block RAM)
interface mem_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32
);
  // fetch port
  logic                     if_req;
  logic [ADDRESS_WIDTH-1:0] if_addr;
  logic                     if_gnt;
  logic                     if_rvalid;
  logic [31:0]              if_rdata;
  logic                     if_err;
  // load/store port
  logic                     d_req;
  logic                     d_we;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [1:0]               d_size;
  logic                     d_unsigned;
  logic [31:0]              d_wdata;
  logic                     d_gnt;
  logic                     d_rvalid;
  logic [31:0]              d_rdata;
  logic                     d_err;
  // block RAM
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic                     ram_we;
  logic [3:0]               ram_be;
  logic [31:0]              ram_di;
  logic [31:0]              ram_do;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, ram_do,
    output if_gnt, if_rvalid, if_rdata, if_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           ram_addr, ram_we, ram_be, ram_di
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_size, d_unsigned, d_wdata, ram_do,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           ram_addr, ram_we, ram_be, ram_di
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port block RAM between the instruction
// fetch port and the load/store port.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave -- fetch port, data port and RAM drive
// Grants are combinational (round-robin on conflict). The RAM has a 1-cycle
// registered read, so a small pending record captured at grant time shapes
// the response presented in the following cycle. Faulted accesses are granted
// and answered with err=1 but never write the RAM.
module mem_port_arbiter #(
  parameter int DEPTH         = 750,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam logic [ADDRESS_WIDTH-1:0] LIMIT = ADDRESS_WIDTH'(DEPTH * 4);

  typedef enum logic { OWN_F = 1'b0, OWN_D = 1'b1 } owner_t;

  typedef struct packed {
    logic       vld;
    owner_t     own;
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       fault;
  } pend_t;

  owner_t rr_last;
  pend_t  pend;

  logic f_gnt, d_gnt, f_fault, d_fault, d_mis;

  // The loser of the previous conflict (or whoever was not granted last) wins.
  assign f_gnt = bus.if_req && (!bus.d_req || rr_last == OWN_D);
  assign d_gnt = bus.d_req && (!bus.if_req || rr_last == OWN_F);

  assign f_fault = (|bus.if_addr[1:0]) || (bus.if_addr >= LIMIT);

  always_comb begin
    case (bus.d_size)
      2'b00:   d_mis = 1'b0;
      2'b01:   d_mis = bus.d_addr[0];
      2'b10:   d_mis = |bus.d_addr[1:0];
      default: d_mis = 1'b1;
    endcase
  end
  assign d_fault = d_mis || (bus.d_addr >= LIMIT);

  // RAM drive: quiet unless granted; only a clean store raises we/be.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_we   = 1'b0;
    bus.ram_be   = 4'b0000;
    bus.ram_di   = 32'h0;
    if (f_gnt) begin
      bus.ram_addr = bus.if_addr;
    end else if (d_gnt) begin
      bus.ram_addr = bus.d_addr;
      if (bus.d_we && !d_fault) begin
        bus.ram_we = 1'b1;
        case (bus.d_size)
          2'b00: begin
            bus.ram_be = 4'b0001 << bus.d_addr[1:0];
            bus.ram_di = {4{bus.d_wdata[7:0]}};
          end
          2'b01: begin
            bus.ram_be = bus.d_addr[1] ? 4'b1100 : 4'b0011;
            bus.ram_di = {2{bus.d_wdata[15:0]}};
          end
          default: begin
            bus.ram_be = 4'b1111;
            bus.ram_di = bus.d_wdata;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= OWN_D;
      pend    <= '0;
    end else begin
      pend.vld <= f_gnt || d_gnt;
      if (f_gnt) begin
        rr_last    <= OWN_F;
        pend.own   <= OWN_F;
        pend.we    <= 1'b0;
        pend.size  <= 2'b10;
        pend.uns   <= 1'b0;
        pend.off   <= bus.if_addr[1:0];
        pend.fault <= f_fault;
      end else if (d_gnt) begin
        rr_last    <= OWN_D;
        pend.own   <= OWN_D;
        pend.we    <= bus.d_we;
        pend.size  <= bus.d_size;
        pend.uns   <= bus.d_unsigned;
        pend.off   <= bus.d_addr[1:0];
        pend.fault <= d_fault;
      end
    end
  end

  // Lane extraction from the word the RAM returns this cycle.
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] load_data, resp_data;

  always_comb begin
    case (pend.off)
      2'd0:    sel_b = bus.ram_do[7:0];
      2'd1:    sel_b = bus.ram_do[15:8];
      2'd2:    sel_b = bus.ram_do[23:16];
      default: sel_b = bus.ram_do[31:24];
    endcase
    sel_h = pend.off[1] ? bus.ram_do[31:16] : bus.ram_do[15:0];
    case (pend.size)
      2'b00:   load_data = {{24{sel_b[7]  && !pend.uns}}, sel_b};
      2'b01:   load_data = {{16{sel_h[15] && !pend.uns}}, sel_h};
      default: load_data = bus.ram_do;
    endcase
    // Stores ack with zero data; faults never leak RAM contents.
    resp_data = (pend.we || pend.fault) ? 32'h0 : load_data;
  end

  assign bus.if_gnt    = f_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = pend.vld && pend.own == OWN_F;
  assign bus.d_rvalid  = pend.vld && pend.own == OWN_D;
  assign bus.if_rdata  = bus.if_rvalid ? resp_data : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid  ? resp_data : 32'h0;
  assign bus.if_err    = bus.if_rvalid && pend.fault;
  assign bus.d_err     = bus.d_rvalid  && pend.fault;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port program/data block RAM between the core's instruction-fetch port and its load/store port. Arbitrates with round-robin on conflict, generates byte enables and lane-replicated write data for SB/SH/SW, extracts and sign/zero-extends LB/LBU/LH/LHU/LW results, and flags misaligned or out-of-range accesses without touching the RAM. Sits between the core and the block RAM (1-cycle registered read, byte-enabled write).

## Interface
- DEPTH, 750, RAM depth in 32-bit words; byte addresses ≥ DEPTH*4 are out of range
- ADDRESS_WIDTH, 32, width of all byte addresses
- clk  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; if_addr held stable until if_gnt
- if_addr  in  ADDRESS_WIDTH  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch response valid (one cycle)
- if_rdata  out  32  fetched word
- if_err  out  1  fetch fault, qualified by if_rvalid
- d_req  in  1  data request; d_* held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDRESS_WIDTH  data byte address
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend loads
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (one cycle)
- d_rdata  out  32  extended load data; 0 for stores and faults
- d_err  out  1  data fault, qualified by d_rvalid
- ram_addr  out  ADDRESS_WIDTH  byte address to RAM (word index = ram_addr[13:2])
- ram_we  out  1  RAM write enable
- ram_be  out  4  RAM byte enables
- ram_di  out  32  RAM write data
- ram_do  in  32  RAM read data, valid the cycle after the address

## Operation
- Grant combinational: one requester only → granted; both → the one not granted last (rr_last register). Reset: rr_last = data, so fetch wins first conflict.
- Fault check on granted request: fetch faults if if_addr[1:0]≠0 or out of range; data faults if d_size=11, half with addr[0]=1, word with addr[1:0]≠0, or out of range. Faulted requests still get gnt, but ram_we=0, ram_be=0.
- Stores: byte → ram_di = {4{wdata[7:0]}}, ram_be = 0001<<addr[1:0]; half → ram_di = {2{wdata[15:0]}}, ram_be = 0011 or 1100 by addr[1]; word → ram_be = 1111.
- Loads/fetches: ram_we=0, ram_be=0.
- No grant: ram_we=0, ram_be=0, ram_addr=0, ram_di=0.
- Pending register captures owner, we, size, unsigned, addr[1:0], fault on each grant; drives the response next cycle.
- Load response: select byte/half by captured offset, sign-extend unless unsigned; word passes through.
- Stores return rvalid with rdata=0 as write ack.

## Timing
- Cycle N: req high → gnt in N; RAM write commits at end of N.
- Cycle N+1: x_rvalid=1, x_rdata from ram_do, x_err from captured fault. Latency exactly 1; no response backpressure.
- Back-to-back grants allowed every cycle; continuous both-req alternates F,D,F,D.
- Response of the other port is never asserted; at most one rvalid per cycle.
- Reset values: all gnt/rvalid/err = 0, rdata = 0, ram_we = 0, ram_be = 0, pending invalid, rr_last = data.
- RESET asserted mid-access: pending response discarded, no rvalid after release; a write already committed stays.
- Requester dropping req before gnt: legal, no effect.

## Test plan
- Reset then if_req, if_addr=0x10, RAM word 4 = 0xDEADBEEF → if_gnt cycle N, if_rvalid N+1, if_rdata=0xDEADBEEF, if_err=0.
- SB d_addr=0x21 wdata=0xA5 → ram_be=0010, ram_di=0xA5A5A5A5; then LB 0x21 → d_rdata=0xFFFFFFA5; LBU → 0x000000A5.
- SH d_addr=0x42 wdata=0x8001, then LH 0x42 → 0xFFFF8001; LHU → 0x00008001; word at 0x40 upper half = 0x8001.
- Both req held 6 cycles from reset → grants F,D,F,D,F,D; each rvalid on correct port one cycle later.
- LW d_addr=0x102, then LH 0x3 and fetch 0xBB8 (≥DEPTH*4) → gnt, no RAM write, err=1 with rvalid, rdata=0.
- SW granted, RESET pulsed low in N+1 → no d_rvalid after release; memory holds stored word.
